// File: rtl/dda_param_loader.sv
// Byte-serial loader for the seven dda posit operands, plus the dda rst/en
// sequencer (one IC-load cycle, then divider-paced Euler steps).
module dda_param_loader #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [7:0]   load_data,
  input  logic         run,
  input  logic         restart,
  input  logic [7:0]   div,
  output logic [N-1:0] icx,
  output logic [N-1:0] icy,
  output logic [N-1:0] icz,
  output logic [N-1:0] sigma,
  output logic [N-1:0] beta,
  output logic [N-1:0] rho,
  output logic [N-1:0] dt,
  output logic         dda_rst,
  output logic         dda_en,
  output logic         loaded
);

  localparam int unsigned BYTES = N / 8;
  localparam int unsigned TOTAL = 7 * BYTES;
  localparam int unsigned BW    = $clog2(TOTAL);

  typedef enum logic [1:0] {LOAD, INIT, RUN} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   bcnt, bcnt_nx, wbyte;
  logic [7:0]      cnt, cnt_nx;
  logic            loaded_nx;
  logic [N-1:0]    opr [7];

  always_comb begin
    state_nx  = state;
    bcnt_nx   = bcnt;
    cnt_nx    = cnt;
    loaded_nx = loaded;
    wbyte     = bcnt;
    dda_rst   = 1'b0;
    dda_en    = 1'b0;
    case (state)
      LOAD: begin
        cnt_nx = '0;
        if (load_valid) begin
          if (bcnt == BW'(TOTAL - 1)) begin
            bcnt_nx   = '0;
            loaded_nx = 1'b1;
            state_nx  = INIT;
          end else begin
            bcnt_nx = bcnt + BW'(1);
          end
        end
      end
      INIT: begin
        dda_rst  = 1'b1;
        dda_en   = 1'b1;
        cnt_nx   = '0;
        state_nx = RUN;
      end
      RUN: begin
        dda_en = run && (cnt == div);
        if (run)
          cnt_nx = (cnt == div) ? '0 : cnt + 8'd1;
        if (restart)
          state_nx = INIT;
      end
      default: state_nx = LOAD;
    endcase
    // A byte outside LOAD aborts the running set and becomes byte 0 of a new one.
    if (load_valid && state != LOAD) begin
      wbyte     = '0;
      bcnt_nx   = BW'(1);
      loaded_nx = 1'b0;
      state_nx  = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      bcnt   <= '0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else begin
      state  <= state_nx;
      bcnt   <= bcnt_nx;
      cnt    <= cnt_nx;
      loaded <= loaded_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 7; i++)
        opr[i] <= '0;
    end else if (load_valid) begin
      for (int unsigned i = 0; i < 7; i++)
        for (int unsigned j = 0; j < BYTES; j++)
          if (wbyte == BW'(i * BYTES + j))
            opr[i][8*j +: 8] <= load_data;
    end
  end

  assign icx   = opr[0];
  assign icy   = opr[1];
  assign icz   = opr[2];
  assign sigma = opr[3];
  assign beta  = opr[4];
  assign rho   = opr[5];
  assign dt    = opr[6];

endmodule

// File: tb/tb_dda_param_loader.sv
// Scoreboard bench for dda_param_loader: expected dda_en pulses (cycle, rst)
// are queued by the stimulus and consumed by a negedge monitor.
module tb_dda_param_loader;

  logic        clk = 1'b0;
  logic        rst_n, load_valid, run, restart;
  logic [7:0]  load_data, div;
  logic [15:0] icx, icy, icz, sigma, beta, rho, dt;
  logic        dda_rst, dda_en, loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0, e2, e3, rr;

  typedef struct {
    int   c;
    logic r;
  } ev_t;
  ev_t exp_q[$];

  dda_param_loader #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .run(run), .restart(restart), .div(div),
    .icx(icx), .icy(icy), .icz(icz), .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
    .dda_rst(dda_rst), .dda_en(dda_en), .loaded(loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic r);
    ev_t e;
    e.c = c;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      load_valid = 1'b1;
      load_data  = first + 8'(i);
    end
  endtask

  task automatic chk_ops(input logic [15:0] x, y, z, s, b, r, d);
    chk("icx", icx, x);
    chk("icy", icy, y);
    chk("icz", icz, z);
    chk("sigma", sigma, s);
    chk("beta", beta, b);
    chk("rho", rho, r);
    chk("dt", dt, d);
  endtask

  // Monitor: every dda_en/dda_rst cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (dda_en || dda_rst)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got en=%0b rst=%0b at cyc %0d expected none",
                 dda_en, dda_rst, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_en", dda_en, 1'b1);
        chk("pulse_rst", dda_rst, e.r);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0;
    run = 1'b1; restart = 1'b0; div = 8'd2;
    #3;
    chk_ops('0, '0, '0, '0, '0, '0, '0);
    chk("reset_loaded", loaded, 1'b0);
    chk("reset_en", {dda_rst, dda_en}, 2'b00);
    #10 rst_n = 1'b1;

    // Full load 0x01..0x0E, div=2 stepping.
    load_seq(8'h01, 14);
    tick();
    load_valid = 1'b0;
    e0 = cyc;
    push(e0, 1'b1);
    push(e0 + 3, 1'b0); push(e0 + 6, 1'b0); push(e0 + 9, 1'b0);
    chk_ops(16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B, 16'h0E0D);
    chk("loaded_full", loaded, 1'b1);

    // run low for 5 cycles with cnt==1; count resumes from 1.
    wait_until(e0 + 11);
    run = 1'b0;
    push(e0 + 17, 1'b0); push(e0 + 20, 1'b0);
    wait_until(e0 + 16);
    run = 1'b1;
    wait_until(e0 + 21);
    div = 8'd0;
    for (int k = 21; k <= 26; k++) push(e0 + k, 1'b0);

    // Reload and restart together: reload wins, no INIT pulse.
    wait_until(e0 + 26);
    rr = cyc;
    load_valid = 1'b1; load_data = 8'hAA; restart = 1'b1;
    tick();
    load_valid = 1'b0; restart = 1'b0;
    chk("reload_en", {dda_rst, dda_en}, 2'b00);
    chk("reload_loaded", loaded, 1'b0);
    chk("reload_icx", icx, 16'h02AA);
    div = 8'd3;
    tick(); tick();
    load_seq(8'h11, 13);
    tick();
    load_valid = 1'b0;
    e2 = cyc;
    push(e2, 1'b1); push(e2 + 4, 1'b0); push(e2 + 8, 1'b0);
    chk_ops(16'h11AA, 16'h1312, 16'h1514, 16'h1716, 16'h1918, 16'h1B1A, 16'h1D1C);
    chk("loaded_second", loaded, 1'b1);

    // Restart alone: one INIT pulse, operands untouched.
    wait_until(e2 + 9);
    restart = 1'b1;
    push(e2 + 10, 1'b1); push(e2 + 14, 1'b0);
    tick();
    restart = 1'b0;
    chk_ops(16'h11AA, 16'h1312, 16'h1514, 16'h1716, 16'h1918, 16'h1B1A, 16'h1D1C);
    chk("restart_loaded", loaded, 1'b1);

    // Six bytes of a reload, then an asynchronous reset mid-cycle.
    wait_until(e2 + 15);
    load_seq(8'h31, 6);
    tick();
    load_valid = 1'b0;
    chk("partial_icx", icx, 16'h3231);
    chk("partial_icz", icz, 16'h3635);
    #2 rst_n = 1'b0;
    #1;
    chk_ops('0, '0, '0, '0, '0, '0, '0);
    chk("async_loaded", loaded, 1'b0);
    chk("async_en", {dda_rst, dda_en}, 2'b00);
    tick();
    rst_n = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    load_seq(8'h41, 14);
    tick();
    load_valid = 1'b0;
    e3 = cyc;
    push(e3, 1'b1); push(e3 + 4, 1'b0);
    chk_ops(16'h4241, 16'h4443, 16'h4645, 16'h4847, 16'h4A49, 16'h4C4B, 16'h4E4D);
    chk("loaded_after_reset", loaded, 1'b1);
    wait_until(e3 + 6);
    chk("pending_pulses", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
